debug_autobaud_multi: RTL and testbench

Parametrised auto-baud detector for the debug UART front end. It watches NUM_RX candidate RX pins and locks onto the first pin that toggles. It measures successive pulse widths on that pin and emits a baud divisor once MATCH_N consecutive divisors agree within TOL. After the selected line goes idle it publishes rx_sel. It can be re-armed at runtime without a reset.

---
 rtl/debug_autobaud_multi.sv | 101 ++++++++++
 tb/tb_debug_autobaud_multi.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/debug_autobaud_multi.sv
// debug_autobaud_multi: locks onto the first toggling RX pin, measures pulse widths and emits a
// baud divisor once MATCH_N consecutive divisors agree, then publishes the pin once the line idles.
module debug_autobaud_multi #(
  parameter int NUM_RX  = 3,
  parameter int CNT_W   = 14,
  parameter int DIV_W   = 8,
  parameter int DIV_LSB = 5,
  parameter int MATCH_N = 3,
  parameter int TOL     = 0,
  parameter int SEL_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disabled,
  input  logic              rearm,
  input  logic [NUM_RX-1:0] rx,
  output logic              wr,
  output logic [DIV_W-1:0]  div,
  output logic [SEL_W-1:0]  rx_sel,
  output logic              locked
);
  typedef enum logic [1:0] {HUNT, WAIT_IDLE, LOCKED} state_t;
  localparam logic [CNT_W-1:0] SAT = '1;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] hist [MATCH_N];
  logic [NUM_RX-1:0] last_rx, edges;
  logic [SEL_W-1:0] chan, first_ch;
  logic [DIV_W-1:0] new_div;
  logic sat, qual, match, rx_chan;
  assign sat = cnt == SAT;
  assign edges = rx ^ last_rx;
  assign new_div = cnt[DIV_LSB+DIV_W-1:DIV_LSB];
  assign rx_chan = rx[chan - 1'b1];
  assign qual = state != LOCKED && (chan == '0 ? state == HUNT && |edges : edges[chan - 1'b1]);
  always_comb begin
    first_ch = '0;
    for (int i = NUM_RX - 1; i >= 0; i--)
      if (edges[i]) first_ch = SEL_W'(i + 1);
  end
  function automatic logic near(input logic [DIV_W-1:0] a, input logic [DIV_W-1:0] b);
    logic [DIV_W:0] d;
    d = a > b ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
    return a != '0 && d <= (DIV_W+1)'(TOL);
  endfunction
  always_comb begin
    match = 1'b1;
    for (int k = 0; k < MATCH_N; k++) match = match && near(hist[k], hist[0]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      cnt <= '0;
      last_rx <= '0;
      chan <= '0;
      wr <= 1'b0;
      div <= '0;
      rx_sel <= '0;
      locked <= 1'b0;
      for (int k = 0; k < MATCH_N; k++) hist[k] <= '0;
    end else begin
      wr <= 1'b0;
      // a saturated idle line keeps its last sample so a late rising edge still restarts the count
      if (!(state == WAIT_IDLE && sat)) last_rx <= rx;
      if (state != LOCKED) cnt <= qual ? '0 : cnt + CNT_W'(!sat);
      if (rearm) begin
        state <= HUNT;
        cnt <= '0;
        chan <= '0;
        locked <= 1'b0;
        for (int k = 0; k < MATCH_N; k++) hist[k] <= '0;
      end else begin
        case (state)
          HUNT:
            if (qual) begin
              if (chan == '0) chan <= first_ch;
              if (disabled) state <= WAIT_IDLE;
              else if (sat) for (int k = 0; k < MATCH_N; k++) hist[k] <= '0;
              else begin
                for (int k = MATCH_N - 1; k > 0; k--) hist[k] <= hist[k-1];
                hist[0] <= new_div;
              end
            end else if (match && !disabled) begin
              wr <= 1'b1;
              div <= hist[0];
              state <= WAIT_IDLE;
            end else if (sat) begin
              chan <= '0;
              for (int k = 0; k < MATCH_N; k++) hist[k] <= '0;
            end
          WAIT_IDLE:
            if (disabled || (sat && rx_chan)) begin
              rx_sel <= chan;
              locked <= 1'b1;
              state <= LOCKED;
            end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_debug_autobaud_multi.sv
// tb_debug_autobaud_multi: directed bench for debug_autobaud_multi; dut0 uses TOL=0, dut1 TOL=1,
// both driven with the same pins.
module tb_debug_autobaud_multi;
  logic clk = 1'b0, rst_n = 1'b0, disabled = 1'b0, rearm = 1'b0;
  logic [2:0] rx = '0;
  logic wr0, wr1, lk0, lk1;
  logic [7:0] div0, div1;
  logic [1:0] sel0, sel1;
  int checks = 0, failures = 0, wrc0 = 0, wrc1 = 0, n;
  typedef struct {
    int ch; bit dis; int np; int p[5];
    int wr0; int div0; int wr1; int div1; int lk; int sel;
  } vec_t;
  vec_t v[7];
  always #5 clk = ~clk;
  debug_autobaud_multi dut0 (.clk(clk), .rst_n(rst_n), .disabled(disabled), .rearm(rearm), .rx(rx),
    .wr(wr0), .div(div0), .rx_sel(sel0), .locked(lk0));
  debug_autobaud_multi #(.TOL(1)) dut1 (.clk(clk), .rst_n(rst_n), .disabled(disabled), .rearm(rearm),
    .rx(rx), .wr(wr1), .div(div1), .rx_sel(sel1), .locked(lk1));
  always @(negedge clk) begin
    wrc0 = rst_n ? wrc0 + int'(wr0) : 0;
    wrc1 = rst_n ? wrc1 + int'(wr1) : 0;
  end
  task automatic cyc(input int c);
    repeat (c) @(negedge clk);
  endtask
  task automatic tog(input int ch);
    rx[ch] = ~rx[ch];
  endtask
  task automatic do_reset;
    rst_n = 1'b0; rx = '0; disabled = 1'b0; rearm = 1'b0;
    cyc(3);
    rst_n = 1'b1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask
  initial begin
    v[0] = '{1, 1'b0, 3, '{321, 321, 321, 0, 0}, 1, 10, 1, 10, 0, 0};
    v[1] = '{0, 1'b0, 3, '{321, 353, 321, 0, 0}, 0, 0, 1, 10, 0, 0};
    v[2] = '{2, 1'b0, 5, '{321, 353, 321, 321, 321}, 1, 10, 1, 10, 0, 0};
    v[3] = '{0, 1'b0, 3, '{641, 641, 641, 0, 0}, 1, 20, 1, 20, 0, 0};
    v[4] = '{1, 1'b0, 3, '{33, 33, 33, 0, 0}, 1, 1, 1, 1, 0, 0};
    v[5] = '{1, 1'b0, 3, '{32, 32, 32, 0, 0}, 0, 0, 0, 0, 0, 0};
    v[6] = '{1, 1'b1, 1, '{321, 0, 0, 0, 0}, 0, 0, 0, 0, 1, 2};
    do_reset;
    chk("rst_wr", int'(wr0), 0);
    chk("rst_div", int'(div0), 0);
    chk("rst_sel", int'(sel0), 0);
    chk("rst_locked", int'(lk0), 0);
    foreach (v[i]) begin
      do_reset;
      disabled = v[i].dis;
      cyc(40);
      tog(v[i].ch);
      for (int j = 0; j < v[i].np; j++) begin
        cyc(v[i].p[j]);
        tog(v[i].ch);
      end
      cyc(5);
      chk($sformatf("v%0d_wr_tol0", i), wrc0, v[i].wr0);
      chk($sformatf("v%0d_div_tol0", i), int'(div0), v[i].div0);
      chk($sformatf("v%0d_wr_tol1", i), wrc1, v[i].wr1);
      chk($sformatf("v%0d_div_tol1", i), int'(div1), v[i].div1);
      chk($sformatf("v%0d_locked", i), int'(lk0), v[i].lk);
      chk($sformatf("v%0d_rx_sel", i), int'(sel0), v[i].sel);
    end
    // simultaneous first edge on ch1 and ch3: ch1 held until saturation, then ch3 wins
    do_reset;
    cyc(40);
    rx[0] = 1'b1; rx[2] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cyc(321);
      tog(2);
    end
    cyc(16500 - 6 * 321);
    chk("sim_hold_wr", wrc0, 0);
    tog(2);
    for (int j = 0; j < 3; j++) begin
      cyc(321);
      tog(2);
    end
    n = 0;
    while (!lk0 && n < 16400) begin
      cyc(1);
      n++;
    end
    chk("sim_lock_time", n, 16385);
    chk("sim_wr", wrc0, 1);
    chk("sim_div", int'(div0), 10);
    chk("sim_rx_sel", int'(sel0), 3);
    // a gap past saturation discards history
    do_reset;
    cyc(40);
    tog(0);
    cyc(321); tog(0);
    cyc(16500); tog(0);
    cyc(5);
    chk("gap_no_wr", wrc0, 0);
    for (int j = 0; j < 3; j++) begin
      cyc(641);
      tog(0);
    end
    cyc(5);
    chk("gap_wr", wrc0, 1);
    chk("gap_div", int'(div0), 20);
    chk("gap_locked", int'(lk0), 0);
    // bypass lock, then rearm colliding with a match, then async reset in WAIT_IDLE
    do_reset;
    disabled = 1'b1;
    cyc(5);
    tog(0);
    cyc(3);
    chk("dis_locked", int'(lk0), 1);
    chk("dis_rx_sel", int'(sel0), 1);
    disabled = 1'b0;
    rearm = 1'b1; cyc(1); rearm = 1'b0;
    cyc(1);
    chk("rearm_locked", int'(lk0), 0);
    chk("rearm_sel_kept", int'(sel0), 1);
    cyc(40);
    tog(2);
    for (int j = 0; j < 3; j++) begin
      cyc(321);
      tog(2);
    end
    cyc(1);
    rearm = 1'b1; cyc(1); rearm = 1'b0;
    cyc(10);
    chk("rearm_no_wr", wrc0, 0);
    chk("rearm_no_lock", int'(lk0), 0);
    chk("rearm_sel_kept2", int'(sel0), 1);
    cyc(40);
    tog(2);
    for (int j = 0; j < 3; j++) begin
      cyc(321);
      tog(2);
    end
    cyc(5);
    chk("rehunt_wr", wrc0, 1);
    chk("rehunt_div", int'(div0), 10);
    chk("rehunt_sel", int'(sel0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_div", int'(div0), 0);
    chk("arst_sel", int'(sel0), 0);
    chk("arst_locked", int'(lk0), 0);
    chk("arst_wr", int'(wr0), 0);
    cyc(2);
    rst_n = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
